// File: rtl/waveform_pkg.sv
// Shared types and small helpers for the triangle waveform generator:
// output-mode and ramp-direction encodings plus the enable decode.
package waveform_pkg;

  typedef enum logic [1:0] {MODE_IDLE, MODE_PWM, MODE_R2R, MODE_FAULT} out_mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} ramp_dir_t;

  function automatic out_mode_t decode_mode(input logic triangle_en,
                                            input logic pwm_enable,
                                            input logic r2r_enable);
    out_mode_t m;
    m = MODE_IDLE;
    if (triangle_en) begin
      if (pwm_enable && r2r_enable) m = MODE_FAULT;
      else if (pwm_enable)          m = MODE_PWM;
      else if (r2r_enable)          m = MODE_R2R;
    end
    return m;
  endfunction

  function automatic logic is_active(input out_mode_t m);
    return (m == MODE_PWM) || (m == MODE_R2R);
  endfunction

endpackage

// File: rtl/pwm_compare.sv
// PWM back end: free-running frame counter, level latched at the frame
// boundary so duty never changes mid-frame, and a registered compare.
module pwm_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] level_in,
  output logic             pwm_out
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    pwm_cnt_d = '0;
    level_d   = '0;
    pwm_d     = 1'b0;
    if (en) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      level_d   = (pwm_cnt_q == CNT_MAX) ? level_in : level_q;
      // At the boundary slot pwm_cnt==max, so the old level can never drive high.
      pwm_d     = (pwm_cnt_q < level_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      level_q   <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      level_q   <= level_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/triangle_wave_gen.sv
// Triangle waveform generator: mode decode, step prescaler and up/down ramp,
// delivered as a parallel R2R code or through the PWM back end.
module triangle_wave_gen
  import waveform_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             triangle_en,
  input  logic             pwm_enable,
  input  logic             r2r_enable,
  output logic             pwm_out,
  output logic [WIDTH-1:0] r2r_out,
  output logic             cycle_done,
  output logic             mode_fault
);

  localparam int               PW        = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]    PS_LAST   = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] RAMP_MAX  = '1;
  localparam logic [WIDTH-1:0] RAMP_ONE  = WIDTH'(1);

  out_mode_t        mode_q, mode_d;
  out_mode_t        prev_mode_q;
  logic             fault_q, fault_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] ramp_q, ramp_d;
  ramp_dir_t        dir_q, dir_d;
  logic [WIDTH-1:0] r2r_q, r2r_d;
  logic             done_q, done_d;
  logic             run;
  logic             tick;
  logic             pwm_en;

  always_comb begin
    mode_d  = decode_mode(triangle_en, pwm_enable, r2r_enable);
    fault_d = (mode_d == MODE_FAULT);
    // A direct PWM<->R2R switch spends one cycle cleared before restarting.
    run     = is_active(mode_q) &&
              !(is_active(prev_mode_q) && (prev_mode_q != mode_q));
    tick    = run && (presc_q == PS_LAST);
    pwm_en  = run && (mode_q == MODE_PWM);

    presc_d = '0;
    ramp_d  = '0;
    dir_d   = DIR_UP;
    r2r_d   = '0;
    done_d  = 1'b0;

    if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      ramp_d  = ramp_q;
      dir_d   = dir_q;
      r2r_d   = (mode_q == MODE_R2R) ? ramp_q : '0;
      if (tick) begin
        if (dir_q == DIR_UP) begin
          if (ramp_q == RAMP_MAX) begin
            ramp_d = ramp_q - 1'b1;
            dir_d  = DIR_DOWN;
          end else begin
            ramp_d = ramp_q + 1'b1;
          end
        end else begin
          if (ramp_q == RAMP_ONE) begin
            ramp_d = '0;
            dir_d  = DIR_UP;
            done_d = 1'b1;
          end else begin
            ramp_d = ramp_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_IDLE;
      prev_mode_q <= MODE_IDLE;
      fault_q     <= 1'b0;
      presc_q     <= '0;
      ramp_q      <= '0;
      dir_q       <= DIR_UP;
      r2r_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      prev_mode_q <= mode_q;
      fault_q     <= fault_d;
      presc_q     <= presc_d;
      ramp_q      <= ramp_d;
      dir_q       <= dir_d;
      r2r_q       <= r2r_d;
      done_q      <= done_d;
    end
  end

  pwm_compare #(.WIDTH(WIDTH)) u_pwm (
    .clk      (clk),
    .reset    (reset),
    .en       (pwm_en),
    .level_in (ramp_q),
    .pwm_out  (pwm_out)
  );

  assign r2r_out    = r2r_q;
  assign cycle_done = done_q;
  assign mode_fault = fault_q;

endmodule

// File: tb/tb_triangle_wave_gen.sv
// Bench for triangle_wave_gen: two instances (PRESCALE 2 and 64, WIDTH 4) checked
// every cycle against a step-count triangle model, directed then random stimulus.
module tb_triangle_wave_gen;

  localparam int W  = 4;
  localparam int M  = 15;
  localparam int F  = 16;
  localparam int P0 = 2;
  localparam int P1 = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         te = 1'b0, pe = 1'b0, re = 1'b0;
  logic         pwm0, cd0, mf0, pwm1, cd1, mf1;
  logic [W-1:0] r2r0, r2r1;

  triangle_wave_gen #(.WIDTH(W), .PRESCALE(P0)) u_dut0 (
    .clk(clk), .reset(reset), .triangle_en(te), .pwm_enable(pe), .r2r_enable(re),
    .pwm_out(pwm0), .r2r_out(r2r0), .cycle_done(cd0), .mode_fault(mf0));

  triangle_wave_gen #(.WIDTH(W), .PRESCALE(P1)) u_dut1 (
    .clk(clk), .reset(reset), .triangle_en(te), .pwm_enable(pe), .r2r_enable(re),
    .pwm_out(pwm1), .r2r_out(r2r1), .cycle_done(cd1), .mode_fault(mf1));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: modes 0 idle, 1 pwm, 2 r2r, 3 fault; c = clocks spent running.
  int mode_m = 0, prev_m = 0, e_mf = 0;
  int c_m[2], lvl_m[2], e_pwm[2], e_r2r[2], e_cd[2];
  int cd_total = 0;

  function automatic int tri_f(input int s);
    int k;
    k = s % (2 * M);
    return (k <= M) ? k : 2 * M - k;
  endfunction

  function automatic int dec(input logic t, input logic p, input logic r);
    if (!t) return 0;
    if (p && r) return 3;
    if (p) return 1;
    if (r) return 2;
    return 0;
  endfunction

  function automatic bit act(input int m);
    return (m == 1) || (m == 2);
  endfunction

  task automatic model_clear();
    mode_m = 0; prev_m = 0; e_mf = 0;
    for (int i = 0; i < 2; i++) begin
      c_m[i] = 0; lvl_m[i] = 0; e_pwm[i] = 0; e_r2r[i] = 0; e_cd[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit run;
    int p;
    if (reset) begin
      model_clear();
      return;
    end
    run = act(mode_m) && !(act(prev_m) && prev_m != mode_m);
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? P0 : P1;
      if (run) begin
        e_r2r[i] = (mode_m == 2) ? tri_f(c_m[i] / p) : 0;
        e_cd[i]  = (((c_m[i] + 1) % p) == 0 && (((c_m[i] + 1) / p) % (2 * M)) == 0) ? 1 : 0;
        if (mode_m == 1) begin
          e_pwm[i] = ((c_m[i] % F) < lvl_m[i]) ? 1 : 0;
          if ((c_m[i] % F) == F - 1) lvl_m[i] = tri_f(c_m[i] / p);
        end else begin
          e_pwm[i] = 0;
          lvl_m[i] = 0;
        end
        c_m[i]++;
      end else begin
        e_r2r[i] = 0; e_cd[i] = 0; e_pwm[i] = 0; lvl_m[i] = 0; c_m[i] = 0;
      end
    end
    prev_m = mode_m;
    mode_m = dec(te, pe, re);
    e_mf = (mode_m == 3) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pwm_p2"},   32'(pwm0), 32'(e_pwm[0]));
    chk({tag, ".r2r_p2"},   32'(r2r0), 32'(e_r2r[0]));
    chk({tag, ".done_p2"},  32'(cd0),  32'(e_cd[0]));
    chk({tag, ".fault_p2"}, 32'(mf0),  32'(e_mf));
    chk({tag, ".pwm_p64"},  32'(pwm1), 32'(e_pwm[1]));
    chk({tag, ".r2r_p64"},  32'(r2r1), 32'(e_r2r[1]));
    chk({tag, ".done_p64"}, 32'(cd1),  32'(e_cd[1]));
    chk({tag, ".fault_p64"},32'(mf1),  32'(e_mf));
    cd_total += e_cd[0] + e_cd[1];
  endtask

  task automatic cyc(input string tag, input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
    end
  endtask

  // Asserts reset between edges and checks the immediate clear.
  task automatic async_reset(input string tag, input int hold);
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    check_all(tag);
    cyc(tag, hold);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    check_all("reset_state");
    cyc("reset_hold", 2);
    #2 reset = 1'b0;

    // R2R held: over two full periods of the fast instance
    te = 1'b1; re = 1'b1;
    cyc("r2r_run", 130);

    // reset mid-ramp (fast instance is on the down slope), then restart
    te = 1'b1; re = 1'b1; pe = 1'b0;
    cyc("r2r_pre_reset", 41);
    async_reset("reset_mid", 2);
    cyc("r2r_restart", 12);

    // PWM held long enough for a full period of the slow instance
    re = 1'b0; pe = 1'b1;
    cyc("pwm_run", 2100);

    // fault, then drop r2r_enable
    re = 1'b1;
    cyc("fault", 10);
    re = 1'b0;
    cyc("fault_clear", 60);

    // direct R2R -> PWM switch mid-ramp
    pe = 1'b0; re = 1'b1;
    cyc("r2r_before_switch", 15);
    pe = 1'b1; re = 1'b0;
    cyc("switch_to_pwm", 40);
    pe = 1'b0; re = 1'b1;
    cyc("switch_to_r2r", 20);

    // waveform disabled with pwm_enable high
    te = 1'b0; pe = 1'b1; re = 1'b0;
    cyc("disabled", 200);

    for (int seg = 0; seg < 40; seg++) begin
      te = ($urandom_range(0, 3) != 0);
      pe = $urandom_range(0, 1);
      re = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) async_reset("rand_reset", $urandom_range(0, 2));
      cyc("random", $urandom_range(1, 120));
    end

    chk("cycle_done_seen", 32'(cd_total > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
